// File: rtl/bicubic_fetch_ctrl.sv
// Bicubic fetch sequencer: walks a TW x TH target raster, fetches each 4x4 source
// neighbourhood from ImgROM, streams it to the datapath and stores the result in ResultSRAM.
module bicubic_fetch_ctrl #(
    parameter int IMG_W  = 100,
    parameter int ROM_AW = 14,
    parameter int RES_AW = 12
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [6:0]        H0,
    input  logic [6:0]        V0,
    input  logic [4:0]        SW,
    input  logic [4:0]        SH,
    input  logic [5:0]        TW,
    input  logic [5:0]        TH,
    output logic              ROM_CEN,
    output logic [ROM_AW-1:0] ROM_A,
    input  logic [7:0]        ROM_Q,
    output logic              win_valid,
    output logic [3:0]        win_idx,
    output logic [7:0]        win_data,
    output logic [5:0]        fx_num,
    output logic [5:0]        fy_num,
    output logic [5:0]        fx_den,
    output logic [5:0]        fy_den,
    input  logic              res_valid,
    input  logic [7:0]        res_data,
    output logic              SRAM_CEN,
    output logic              SRAM_WEN,
    output logic [RES_AW-1:0] SRAM_A,
    output logic [7:0]        SRAM_D,
    output logic              DONE
);

    typedef enum logic [2:0] {
        S_IDLE, S_PREP, S_FETCH, S_DRAIN, S_WAIT, S_WRITE, S_FIN
    } state_t;

    state_t            state;
    logic [6:0]        h0_q, v0_q;
    logic [5:0]        tw_q, th_q;
    logic [4:0]        x_step, y_step;
    logic [5:0]        tx, ty;
    logic [4:0]        x_int, y_int;
    logic [6:0]        x_rem, y_rem;
    logic [RES_AW-1:0] out_addr;
    logic [3:0]        tap;

    logic              x_ge, y_ge;
    logic [3:0]        tap_sel;
    logic [6:0]        row_sel, col_sel;
    logic [ROM_AW-1:0] rom_a_next;

    // Returns clamp(base + off + t - 1, 0, IMG_W-1); the sum is kept biased by +1 to stay unsigned.
    function automatic logic [6:0] clamp_coord(input logic [6:0] base, input logic [4:0] off,
                                               input logic [1:0] t);
        logic [8:0] s;
        s = {2'b00, base} + {4'b0000, off} + {7'd0, t};
        if (s == 9'd0)
            clamp_coord = 7'd0;
        else if (s > 9'(IMG_W))
            clamp_coord = 7'(IMG_W - 1);
        else
            clamp_coord = 7'(s - 9'd1);
    endfunction

    // NOTE: ROM_A is a registered output, so the address for the cycle after this one is
    // computed here from the tap that will be presented next.
    always_comb begin
        x_ge    = x_rem >= {1'b0, fx_den};
        y_ge    = y_rem >= {1'b0, fy_den};
        tap_sel = 4'd0;
        if (state == S_FETCH)
            tap_sel = tap + 4'd1;
        row_sel    = clamp_coord(v0_q, y_int, tap_sel[3:2]);
        col_sel    = clamp_coord(h0_q, x_int, tap_sel[1:0]);
        rom_a_next = ROM_AW'(row_sel) * ROM_AW'(IMG_W) + ROM_AW'(col_sel);
    end

    // NOTE: ROM_Q is already registered inside the ROM, so tap data passes straight through
    // and only its qualifiers are registered; gating keeps it at zero outside a tap.
    assign win_data = win_valid ? ROM_Q : 8'd0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            ROM_CEN   <= 1'b1;
            ROM_A     <= '0;
            win_valid <= 1'b0;
            win_idx   <= 4'd0;
            fx_num    <= 6'd0;
            fy_num    <= 6'd0;
            fx_den    <= 6'd0;
            fy_den    <= 6'd0;
            SRAM_CEN  <= 1'b1;
            SRAM_WEN  <= 1'b1;
            SRAM_A    <= '0;
            SRAM_D    <= 8'd0;
            DONE      <= 1'b0;
            h0_q      <= 7'd0;
            v0_q      <= 7'd0;
            tw_q      <= 6'd0;
            th_q      <= 6'd0;
            x_step    <= 5'd0;
            y_step    <= 5'd0;
            tx        <= 6'd0;
            ty        <= 6'd0;
            x_int     <= 5'd0;
            y_int     <= 5'd0;
            x_rem     <= 7'd0;
            y_rem     <= 7'd0;
            out_addr  <= '0;
            tap       <= 4'd0;
        end else begin
            // Each tap leaves the ROM one cycle after its address was presented.
            win_valid <= (state == S_FETCH);
            if (state == S_FETCH)
                win_idx <= tap;

            case (state)
                S_IDLE: begin
                    h0_q     <= H0;
                    v0_q     <= V0;
                    tw_q     <= TW;
                    th_q     <= TH;
                    fx_den   <= (TW > 6'd1) ? TW - 6'd1 : 6'd1;
                    fy_den   <= (TH > 6'd1) ? TH - 6'd1 : 6'd1;
                    x_step   <= (TW > 6'd1 && SW != 5'd0) ? SW - 5'd1 : 5'd0;
                    y_step   <= (TH > 6'd1 && SH != 5'd0) ? SH - 5'd1 : 5'd0;
                    tx       <= 6'd0;
                    ty       <= 6'd0;
                    x_int    <= 5'd0;
                    y_int    <= 5'd0;
                    x_rem    <= 7'd0;
                    y_rem    <= 7'd0;
                    out_addr <= '0;
                    tap      <= 4'd0;
                    state    <= S_PREP;
                end
                S_PREP: begin
                    if (x_ge || y_ge) begin
                        if (x_ge) begin
                            x_rem <= x_rem - {1'b0, fx_den};
                            x_int <= x_int + 5'd1;
                        end
                        if (y_ge) begin
                            y_rem <= y_rem - {1'b0, fy_den};
                            y_int <= y_int + 5'd1;
                        end
                    end else begin
                        fx_num  <= x_rem[5:0];
                        fy_num  <= y_rem[5:0];
                        ROM_CEN <= 1'b0;
                        ROM_A   <= rom_a_next;
                        tap     <= 4'd0;
                        state   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (tap == 4'd15) begin
                        ROM_CEN <= 1'b1;
                        state   <= S_DRAIN;
                    end else begin
                        tap   <= tap + 4'd1;
                        ROM_A <= rom_a_next;
                    end
                end
                S_DRAIN: state <= S_WAIT;
                S_WAIT: begin
                    if (res_valid) begin
                        SRAM_CEN <= 1'b0;
                        SRAM_WEN <= 1'b0;
                        SRAM_A   <= out_addr;
                        SRAM_D   <= res_data;
                        state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    SRAM_CEN <= 1'b1;
                    SRAM_WEN <= 1'b1;
                    out_addr <= out_addr + 1'b1;
                    if (tx == tw_q - 6'd1) begin
                        tx    <= 6'd0;
                        x_int <= 5'd0;
                        x_rem <= 7'd0;
                        if (ty == th_q - 6'd1) begin
                            DONE  <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            ty    <= ty + 6'd1;
                            y_rem <= y_rem + {2'b00, y_step};
                            state <= S_PREP;
                        end
                    end else begin
                        tx    <= tx + 6'd1;
                        x_rem <= x_rem + {2'b00, x_step};
                        state <= S_PREP;
                    end
                end
                S_FIN:   DONE <= 1'b1;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bicubic_fetch_ctrl.sv
// Scoreboard bench for bicubic_fetch_ctrl: a position/address model fills expectation queues,
// a monitor checks ROM accesses, window taps, fractions, PREP timing and SRAM writes.
module tb_bicubic_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [6:0]  H0 = '0, V0 = '0;
    logic [4:0]  SW = '0, SH = '0;
    logic [5:0]  TW = '0, TH = '0;
    logic        ROM_CEN;
    logic [13:0] ROM_A;
    logic [7:0]  ROM_Q = '0;
    logic        win_valid;
    logic [3:0]  win_idx;
    logic [7:0]  win_data;
    logic [5:0]  fx_num, fy_num, fx_den, fy_den;
    logic        res_valid = 1'b0;
    logic [7:0]  res_data = '0;
    logic        SRAM_CEN, SRAM_WEN;
    logic [11:0] SRAM_A;
    logic [7:0]  SRAM_D;
    logic        DONE;

    bicubic_fetch_ctrl dut (
        .CLK(CLK), .RST(RST), .H0(H0), .V0(V0), .SW(SW), .SH(SH), .TW(TW), .TH(TH),
        .ROM_CEN(ROM_CEN), .ROM_A(ROM_A), .ROM_Q(ROM_Q),
        .win_valid(win_valid), .win_idx(win_idx), .win_data(win_data),
        .fx_num(fx_num), .fy_num(fy_num), .fx_den(fx_den), .fy_den(fy_den),
        .res_valid(res_valid), .res_data(res_data),
        .SRAM_CEN(SRAM_CEN), .SRAM_WEN(SRAM_WEN), .SRAM_A(SRAM_A), .SRAM_D(SRAM_D),
        .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct { int idx; int data; int fx; int fy; } tap_t;
    typedef struct { int addr; int fx; int fy; } wr_t;

    int   rom_exp[$];
    int   prep_exp[$];
    tap_t tap_exp[$];
    wr_t  wr_exp[$];
    int   wdata_exp[$];

    int checks = 0, failures = 0;
    int cyc = 0, ref_cyc = 0, rom_tap_cnt = 0, writes_done = 0;
    int last_write_cyc = 0, done_cyc = -1;
    int exp_xden = 0, exp_yden = 0, fixed_delay = -1;
    bit awaiting_write = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [7:0] rom_val(input int a);
        return 8'((a * 37) ^ (a >> 5));
    endfunction

    always @(posedge CLK) if (ROM_CEN === 1'b0) ROM_Q <= rom_val(int'(ROM_A));

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int clampc(input int v);
        return (v < 0) ? 0 : ((v > 99) ? 99 : v);
    endfunction

    // Source position of target (tx,ty) is tx*(SW-1)/(TW-1): integer part and remainder.
    task automatic build_expected(input int h0, v0, sw, sh, tw, th);
        int dx, dy, sx, sy, xi, xr, yi, yr, px, py, a;
        dx = (tw > 1) ? tw - 1 : 1;
        dy = (th > 1) ? th - 1 : 1;
        sx = (tw > 1) ? sw - 1 : 0;
        sy = (th > 1) ? sh - 1 : 0;
        exp_xden = dx;
        exp_yden = dy;
        for (int ty = 0; ty < th; ty++) begin
            for (int tx = 0; tx < tw; tx++) begin
                xi = tx * sx / dx;  xr = tx * sx % dx;
                yi = ty * sy / dy;  yr = ty * sy % dy;
                px = (tx == 0) ? 0 : xi - (tx - 1) * sx / dx;
                py = (tx == 0 && ty > 0) ? yi - (ty - 1) * sy / dy : 0;
                prep_exp.push_back(1 + ((px > py) ? px : py));
                for (int k = 0; k < 16; k++) begin
                    a = clampc(v0 + yi - 1 + k / 4) * 100 + clampc(h0 + xi - 1 + k % 4);
                    rom_exp.push_back(a);
                    tap_exp.push_back('{k, int'(rom_val(a)), xr, yr});
                end
                wr_exp.push_back('{ty * tw + tx, xr, yr});
            end
        end
    endtask

    task automatic clear_queues();
        rom_exp.delete(); prep_exp.delete(); tap_exp.delete();
        wr_exp.delete(); wdata_exp.delete();
        writes_done = 0;
        done_cyc    = -1;
    endtask

    task automatic check_reset_values();
        check("rst_rom_cen", ROM_CEN, 1);    check("rst_sram_cen", SRAM_CEN, 1);
        check("rst_sram_wen", SRAM_WEN, 1);  check("rst_win_valid", win_valid, 0);
        check("rst_done", DONE, 0);          check("rst_rom_a", ROM_A, 0);
        check("rst_sram_a", SRAM_A, 0);      check("rst_sram_d", SRAM_D, 0);
        check("rst_fx_num", fx_num, 0);      check("rst_fy_num", fy_num, 0);
        check("rst_fx_den", fx_den, 0);      check("rst_fy_den", fy_den, 0);
        check("rst_win_idx", win_idx, 0);    check("rst_win_data", win_data, 0);
    endtask

    // Datapath stand-in: answers each window after a delay, plus spurious strobes mid-fetch.
    initial begin
        int cd;
        cd = 0;
        forever begin
            @(negedge CLK);
            res_valid = 1'b0;
            if (RST) begin
                cd = 0;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    res_valid = 1'b1;
                    res_data  = 8'($urandom);
                    wdata_exp.push_back(int'(res_data));
                end
            end else if (win_valid && win_idx == 4'd15) begin
                cd = ((fixed_delay < 0) ? int'($urandom_range(0, 4)) : fixed_delay) + 1;
            end else if (win_valid && win_idx == 4'd3 && $urandom_range(0, 2) == 0) begin
                res_valid = 1'b1;
                res_data  = 8'($urandom);
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a ROM access, a tap or a write.
    initial begin
        tap_t t;
        wr_t  w;
        forever begin
            @(negedge CLK);
            if (RST) begin
                ref_cyc        = cyc + 1;
                rom_tap_cnt    = 0;
                awaiting_write = 0;
            end else begin
                if (awaiting_write) begin
                    check("rom_idle_in_wait", ROM_CEN, 1);
                    if (wr_exp.size() > 0) begin
                        check("fx_num_hold", fx_num, wr_exp[0].fx);
                        check("fy_num_hold", fy_num, wr_exp[0].fy);
                    end
                end
                if (ROM_CEN == 1'b0) begin
                    check("rom_access_expected", int'(rom_exp.size() > 0), 1);
                    if (rom_exp.size() > 0) begin
                        if (rom_tap_cnt == 0 && prep_exp.size() > 0)
                            check("prep_cycles", cyc - ref_cyc - 1, prep_exp.pop_front());
                        check("rom_addr", int'(ROM_A), rom_exp.pop_front());
                    end
                    rom_tap_cnt = (rom_tap_cnt + 1) % 16;
                end
                if (win_valid) begin
                    check("tap_expected", int'(tap_exp.size() > 0), 1);
                    if (tap_exp.size() > 0) begin
                        t = tap_exp.pop_front();
                        check("win_idx", int'(win_idx), t.idx);
                        check("win_data", int'(win_data), t.data);
                        check("fx_num", int'(fx_num), t.fx);
                        check("fy_num", int'(fy_num), t.fy);
                        check("fx_den", int'(fx_den), exp_xden);
                        check("fy_den", int'(fy_den), exp_yden);
                        if (t.idx == 15) awaiting_write = 1;
                    end
                end
                if (SRAM_CEN == 1'b0) begin
                    check("sram_wen", SRAM_WEN, 0);
                    check("done_before_last", DONE, 0);
                    check("write_expected", int'(wr_exp.size() > 0 && wdata_exp.size() > 0), 1);
                    if (wr_exp.size() > 0 && wdata_exp.size() > 0) begin
                        w = wr_exp.pop_front();
                        check("sram_a", int'(SRAM_A), w.addr);
                        check("sram_d", int'(SRAM_D), wdata_exp.pop_front());
                        check("fx_at_write", int'(fx_num), w.fx);
                        check("fy_at_write", int'(fy_num), w.fy);
                    end
                    awaiting_write = 0;
                    ref_cyc        = cyc;
                    last_write_cyc = cyc;
                    writes_done++;
                end
                if (DONE && done_cyc < 0) done_cyc = cyc;
            end
        end
    end

    task automatic run_raster(input int h0, v0, sw, sh, tw, th, dly, abort_px);
        int  budget;
        bit  found;
        budget      = tw * th * 130 + 200;
        fixed_delay = dly;
        @(posedge CLK); #1;
        RST = 1'b1;
        H0 = 7'(h0); V0 = 7'(v0); SW = 5'(sw); SH = 5'(sh); TW = 6'(tw); TH = 6'(th);
        @(posedge CLK);
        @(negedge CLK);
        check_reset_values();
        clear_queues();
        build_expected(h0, v0, sw, sh, tw, th);
        @(posedge CLK); #1;
        RST = 1'b0;

        if (abort_px >= 0) begin
            found = 0;
            for (int n = 0; n < budget && !found; n++) begin
                @(posedge CLK);
                if (writes_done == abort_px && rom_tap_cnt == 6) found = 1;
            end
            check("abort_point_reached", int'(found), 1);
            #1 RST = 1'b1;
            @(posedge CLK); #1;
            RST = 1'b0;
            clear_queues();
            build_expected(h0, v0, sw, sh, tw, th);
            @(negedge CLK);
            check_reset_values();
        end

        found = 0;
        for (int n = 0; n < budget && !found; n++) begin
            @(negedge CLK);
            if (DONE) found = 1;
        end
        check("done_reached", int'(found), 1);
        if (found) begin
            repeat (3) @(negedge CLK);
            check("fin_done_held", DONE, 1);
            check("fin_rom_cen", ROM_CEN, 1);
            check("fin_sram_cen", SRAM_CEN, 1);
            check("fin_win_valid", win_valid, 0);
            check("write_count", writes_done, tw * th);
            check("done_latency", done_cyc, last_write_cyc + 1);
            check("queues_drained", rom_exp.size() + tap_exp.size() + wr_exp.size()
                  + wdata_exp.size() + prep_exp.size(), 0);
        end
    endtask

    initial begin
        int h0, v0, sw, sh, tw, th;
        run_raster(0, 0, 4, 4, 7, 7, -1, -1);
        run_raster(96, 96, 4, 4, 4, 4, -1, -1);
        run_raster(10, 20, 7, 9, 1, 1, -1, -1);
        run_raster(3, 40, 20, 20, 5, 5, -1, -1);
        run_raster(50, 30, 6, 5, 3, 3, 37, -1);
        run_raster(5, 5, 8, 8, 5, 5, -1, 10);
        repeat (4) begin
            h0 = int'($urandom_range(0, 127));
            v0 = int'($urandom_range(0, 127));
            sw = int'($urandom_range(1, 31));
            sh = int'($urandom_range(1, 31));
            tw = int'($urandom_range(1, 10));
            th = int'($urandom_range(1, 6));
            run_raster(h0, v0, sw, sh, tw, th, -1, -1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
